// File: rtl/fetch_bp_pkg.sv
// Shared types for the fetch-stage branch predictor: counter encoding, BTB entry layout.
// Pure declarations; no timing or flow control of its own.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam ctr_t CTR_RESET = WNT;
  localparam ctr_t CTR_ALLOC = WT;

  // Tag is stored zero-extended to the widest possible tag so the struct stays unparameterised.
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [29:0] target;
    ctr_t        ctr;
  } btb_entry_t;

  function automatic ctr_t ctr_next(ctr_t c, logic taken);
    ctr_t n;
    n = c;
    if (taken) begin
      if (c != ST) n = ctr_t'(c + 2'd1);
    end else begin
      if (c != SNT) n = ctr_t'(c - 2'd1);
    end
    return n;
  endfunction

endpackage

// File: rtl/fetch_bp_btb.sv
// Direct-mapped BTB with 2-bit direction counters: combinational lookup port, edge-triggered update port.
// Lookup is zero-latency and sees pre-update contents; updates always accepted, never stall.
module btb
  import bp_pkg::*;
#(
  parameter int ENTRIES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:2] lookup_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_en,
  input  logic [31:2] upd_pc,
  input  logic        upd_taken,
  input  logic [31:2] upd_target
);

  localparam int IDX = $clog2(ENTRIES);

  btb_entry_t mem [ENTRIES];

  logic [IDX-1:0] lk_idx;
  logic [IDX-1:0] up_idx;
  logic [29:0]    lk_tag;
  logic [29:0]    up_tag;
  btb_entry_t     lk_e;
  btb_entry_t     up_e;
  logic           lk_hit;
  logic           up_hit;

  assign lk_idx = lookup_pc[IDX+1:2];
  assign lk_tag = 30'(lookup_pc[31:IDX+2]);
  assign lk_e   = mem[lk_idx];
  assign lk_hit = lk_e.valid && (lk_e.tag == lk_tag);

  assign pred_taken  = lk_hit && ((lk_e.ctr == WT) || (lk_e.ctr == ST));
  assign pred_target = lk_hit ? {lk_e.target, 2'b00} : 32'h0;

  assign up_idx = upd_pc[IDX+1:2];
  assign up_tag = 30'(upd_pc[31:IDX+2]);
  assign up_e   = mem[up_idx];
  assign up_hit = up_e.valid && (up_e.tag == up_tag);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem[i] <= '{valid: 1'b0, tag: 30'h0, target: 30'h0, ctr: CTR_RESET};
      end
    end else if (upd_en) begin
      if (up_hit) begin
        if (upd_taken) mem[up_idx].target <= upd_target;
        mem[up_idx].ctr <= ctr_next(up_e.ctr, upd_taken);
      end else if (upd_taken) begin
        // A taken miss evicts whatever aliases at this index.
        mem[up_idx] <= '{valid: 1'b1, tag: up_tag, target: upd_target, ctr: CTR_ALLOC};
      end
    end
  end

endmodule

// File: rtl/fetch_bp.sv
// Fetch PC generator: next-PC mux, PC register, mispredict detect and perf counters around the BTB.
// PCF updates one edge after the selection; a mispredict redirect overrides StallF.
module fetch_bp
  import bp_pkg::*;
#(
  parameter int          BTB_ENTRIES = 64,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        ResolveE,
  input  logic [31:0] PCE,
  input  logic        ActualTakenE,
  input  logic [31:0] ActualTargetE,
  input  logic        PredTakenE,
  input  logic [31:0] PredTargetE,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  output logic        MispredictE,
  output logic [31:0] BranchCount,
  output logic [31:0] MispredictCount
);

  // PC held as a word address so the low two bits are zero by construction.
  logic [31:2] pc_q;
  logic [31:2] pc_d;
  logic [31:2] redirect_pc;
  logic        unused_lsbs;

  assign unused_lsbs = ^{PCE[1:0], ActualTargetE[1:0], PredTargetE[1:0]};

  assign PCF      = {pc_q, 2'b00};
  assign PCPlus4F = PCF + 32'd4;

  btb #(.ENTRIES(BTB_ENTRIES)) u_btb (
    .clk        (clk),
    .rst        (reset),
    .lookup_pc  (pc_q),
    .pred_taken (PredTakenF),
    .pred_target(PredTargetF),
    .upd_en     (ResolveE),
    .upd_pc     (PCE[31:2]),
    .upd_taken  (ActualTakenE),
    .upd_target (ActualTargetE[31:2])
  );

  assign MispredictE = ResolveE &&
                       ((ActualTakenE != PredTakenE) ||
                        (ActualTakenE && (ActualTargetE[31:2] != PredTargetE[31:2])));

  assign redirect_pc = ActualTakenE ? ActualTargetE[31:2] : (PCE[31:2] + 30'd1);

  always_comb begin
    pc_d = PCPlus4F[31:2];
    if (MispredictE)     pc_d = redirect_pc;
    else if (StallF)     pc_d = pc_q;
    else if (PredTakenF) pc_d = PredTargetF[31:2];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q            <= RESET_PC[31:2];
      BranchCount     <= 32'h0;
      MispredictCount <= 32'h0;
    end else begin
      pc_q <= pc_d;
      if (ResolveE)    BranchCount     <= BranchCount + 32'd1;
      if (MispredictE) MispredictCount <= MispredictCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_bp.sv
// Directed bench for fetch_bp with RESET_PC = 0x100 and a 64-entry BTB.
module tb_fetch_bp;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallF;
  logic        ResolveE;
  logic [31:0] PCE;
  logic        ActualTakenE;
  logic [31:0] ActualTargetE;
  logic        PredTakenE;
  logic [31:0] PredTargetE;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        MispredictE;
  logic [31:0] BranchCount;
  logic [31:0] MispredictCount;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_bp #(.BTB_ENTRIES(64), .RESET_PC(32'h100)) dut (
    .clk            (clk),
    .reset          (reset),
    .StallF         (StallF),
    .ResolveE       (ResolveE),
    .PCE            (PCE),
    .ActualTakenE   (ActualTakenE),
    .ActualTargetE  (ActualTargetE),
    .PredTakenE     (PredTakenE),
    .PredTargetE    (PredTargetE),
    .PCF            (PCF),
    .PCPlus4F       (PCPlus4F),
    .PredTakenF     (PredTakenF),
    .PredTargetF    (PredTargetF),
    .MispredictE    (MispredictE),
    .BranchCount    (BranchCount),
    .MispredictCount(MispredictCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ResolveE      = 1'b0;
    PCE           = 32'h0;
    ActualTakenE  = 1'b0;
    ActualTargetE = 32'h0;
    PredTakenE    = 1'b0;
    PredTargetE   = 32'h0;
  endtask

  task automatic resolve(input logic [31:0] pce, input logic taken, input logic [31:0] tgt,
                         input logic ptaken, input logic [31:0] ptgt);
    ResolveE      = 1'b1;
    PCE           = pce;
    ActualTakenE  = taken;
    ActualTargetE = tgt;
    PredTakenE    = ptaken;
    PredTargetE   = ptgt;
  endtask

  // Not-taken resolve at 0xC that was predicted taken: redirects fetch to 0x10.
  task automatic redirect10();
    resolve(32'hC, 1'b0, 32'h0, 1'b1, 32'h50);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    StallF = 1'b0;
    idle();
    #1;
    chk("rst_pcf",    PCF,             32'h100);
    chk("rst_pcp4",   PCPlus4F,        32'h104);
    chk("rst_ptk",    {31'h0, PredTakenF}, 32'h0);
    chk("rst_ptgt",   PredTargetF,     32'h0);
    chk("rst_bcnt",   BranchCount,     32'h0);
    chk("rst_mcnt",   MispredictCount, 32'h0);
    chk("rst_mis",    {31'h0, MispredictE}, 32'h0);

    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rel_pcf", PCF, 32'h100);
    step();
    chk("seq_104", PCF, 32'h104);
    chk("seq_104_ptk", {31'h0, PredTakenF}, 32'h0);
    step();
    chk("seq_108", PCF, 32'h108);
    chk("seq_108_ptk", {31'h0, PredTakenF}, 32'h0);

    // Taken branch at 0x10 with no prediction allocates the entry.
    resolve(32'h10, 1'b1, 32'h40, 1'b0, 32'h0);
    #1;
    chk("alloc_mis", {31'h0, MispredictE}, 32'h1);
    step();
    chk("alloc_pcf", PCF, 32'h40);
    redirect10();
    #1;
    chk("redir_mis", {31'h0, MispredictE}, 32'h1);
    step();
    chk("fetch10_pcf",  PCF, 32'h10);
    chk("fetch10_ptk",  {31'h0, PredTakenF}, 32'h1);
    chk("fetch10_ptgt", PredTargetF, 32'h40);
    step();
    chk("pred_follow", PCF, 32'h40);
    chk("bcnt_2", BranchCount,     32'd2);
    chk("mcnt_2", MispredictCount, 32'd2);

    // Two not-taken resolves walk the counter 10 -> 01 -> 00.
    resolve(32'h10, 1'b0, 32'h0, 1'b1, 32'h40);
    #1;
    chk("nt1_mis", {31'h0, MispredictE}, 32'h1);
    step();
    chk("nt1_pcf", PCF, 32'h14);
    resolve(32'h10, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("nt2_mis", {31'h0, MispredictE}, 32'h0);
    step();
    chk("nt2_pcf", PCF, 32'h18);
    chk("bcnt_4", BranchCount,     32'd4);
    chk("mcnt_3", MispredictCount, 32'd3);
    redirect10();
    step();
    chk("nt_fetch_pcf",  PCF, 32'h10);
    chk("nt_fetch_ptk",  {31'h0, PredTakenF}, 32'h0);
    chk("nt_fetch_ptgt", PredTargetF, 32'h40);

    // One taken from 00 only reaches 01: still predicted not-taken.
    resolve(32'h10, 1'b1, 32'h40, 1'b0, 32'h0);
    #1;
    chk("sat_lookup_ptk", {31'h0, PredTakenF}, 32'h0);
    step();
    chk("sat_pcf", PCF, 32'h40);
    redirect10();
    step();
    chk("ctr01_ptk", {31'h0, PredTakenF}, 32'h0);
    resolve(32'h10, 1'b1, 32'h40, 1'b0, 32'h0);
    step();
    chk("ctr10_pcf", PCF, 32'h40);

    // Predicted taken but wrong target.
    resolve(32'h10, 1'b1, 32'h80, 1'b1, 32'h40);
    #1;
    chk("tgt_mis", {31'h0, MispredictE}, 32'h1);
    step();
    chk("tgt_pcf", PCF, 32'h80);
    redirect10();
    step();
    chk("tgt_ptk",  {31'h0, PredTakenF}, 32'h1);
    chk("tgt_ptgt", PredTargetF, 32'h80);

    // Update to the index being looked up: lookup shows the old target.
    resolve(32'h10, 1'b1, 32'h90, 1'b1, 32'h80);
    #1;
    chk("same_idx_ptgt", PredTargetF, 32'h80);
    chk("same_idx_mis",  {31'h0, MispredictE}, 32'h1);
    step();
    chk("same_idx_pcf", PCF, 32'h90);

    // Correct prediction; target low bits are ignored.
    resolve(32'h10, 1'b1, 32'h93, 1'b1, 32'h90);
    #1;
    chk("lsb_mis", {31'h0, MispredictE}, 32'h0);
    step();
    chk("lsb_pcf", PCF, 32'h94);
    chk("bcnt_12", BranchCount,     32'd12);
    chk("mcnt_10", MispredictCount, 32'd10);

    // Stall at 0x20.
    resolve(32'h1C, 1'b0, 32'h0, 1'b1, 32'h50);
    step();
    chk("to20_pcf", PCF, 32'h20);
    StallF = 1'b1;
    resolve(32'h30, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("stall_res_mis", {31'h0, MispredictE}, 32'h0);
    step();
    chk("stall1_pcf", PCF, 32'h20);
    chk("stall_bcnt", BranchCount, 32'd14);
    step();
    chk("stall2_pcf", PCF, 32'h20);
    step();
    chk("stall3_pcf", PCF, 32'h20);
    resolve(32'h60, 1'b1, 32'h200, 1'b0, 32'h0);
    #1;
    chk("stall_mis", {31'h0, MispredictE}, 32'h1);
    step();
    chk("stall_redir_pcf", PCF, 32'h200);
    StallF = 1'b0;
    chk("bcnt_15", BranchCount,     32'd15);
    chk("mcnt_12", MispredictCount, 32'd12);

    // Mid-run reset with pending redirect and stall on the inputs.
    @(posedge clk);
    #1;
    reset  = 1'b1;
    StallF = 1'b1;
    redirect10();
    #1;
    chk("mrst_mcnt", MispredictCount, 32'h0);
    chk("mrst_bcnt", BranchCount,     32'h0);
    chk("mrst_pcf",  PCF,             32'h100);
    chk("mrst_mis",  {31'h0, MispredictE}, 32'h1);
    @(posedge clk);
    #1;
    chk("mrst_hold_pcf", PCF, 32'h100);
    reset = 1'b0;
    #1;
    chk("mrst_rel_pcf", PCF, 32'h100);
    step();
    StallF = 1'b0;
    #1;
    chk("mrst_redir_pcf", PCF, 32'h10);
    chk("mrst_ptk",  {31'h0, PredTakenF}, 32'h0);
    chk("mrst_ptgt", PredTargetF, 32'h0);
    chk("mrst_bcnt1", BranchCount,     32'd1);
    chk("mrst_mcnt1", MispredictCount, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
